// File: rtl/rob_pkg.sv
// Shared defaults and types for the reorder buffer controller.
package rob_pkg;
    localparam int DATA_W_DEF = 512;
    localparam int DEPTH_DEF  = 256;
    localparam int TAG_W_DEF  = $clog2(DEPTH_DEF);

    typedef logic [TAG_W_DEF-1:0] tag_t;
endpackage

// File: rtl/rob_if.sv
// Allocate / fill / in-order read bundle between a producer and rob_ctrl.
interface rob_if
    import rob_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              alloc_req;
    logic              alloc_gnt;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wr_en;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [TAG_W:0]    count;
    logic              full;
    logic              empty;
    logic              wr_err;

    modport master (
        output alloc_req, wr_en, wr_tag, wr_data, rd_ready,
        input  alloc_gnt, alloc_tag, rd_valid, rd_data, count, full, empty, wr_err
    );

    modport slave (
        input  alloc_req, wr_en, wr_tag, wr_data, rd_ready,
        output alloc_gnt, alloc_tag, rd_valid, rd_data, count, full, empty, wr_err
    );
endinterface

// File: rtl/rob_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module rob_ram_sdp #(
    parameter int W  = 32,
    parameter int D  = 8,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer: in-order tag allocation, out-of-order fill, in-order drain
// through a one-cycle RAM read into a 2-entry output FIFO.
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic  clk,
    input  logic  rst,
    rob_if.slave  bus
);
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0]  head, tail;
    logic [TAG_W:0]    cnt;
    logic [DEPTH-1:0]  filled;
    logic              in_flight;
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] fifo_q0, fifo_q1, ram_q;
    logic              wr_err_q;
    logic              full, alloc, pop, fetch, fill_ok;
    logic [2:0]        occ;

    assign full    = (cnt == DEPTH_CNT);
    assign alloc   = bus.alloc_req && !full;
    assign fill_ok = bus.wr_en && !filled[bus.wr_tag];
    assign pop     = (fifo_cnt != 2'd0) && bus.rd_ready;
    // Fetch only if the read, once landed, still fits behind what survives this pop.
    assign occ     = 3'(in_flight) + 3'(fifo_cnt) - 3'(pop);
    assign fetch   = filled[head] && (occ < 3'd2);

    rob_ram_sdp #(.W(DATA_W), .D(DEPTH)) u_ram (
        .clk   (clk),
        .we    (fill_ok),
        .waddr (bus.wr_tag),
        .wdata (bus.wr_data),
        .re    (fetch),
        .raddr (head),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            filled    <= '0;
            in_flight <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            if (alloc) tail <= tail + 1'b1;
            if (fetch) begin
                head         <= head + 1'b1;
                filled[head] <= 1'b0;
            end
            // Never the same bit as the fetch clear: fill requires the bit to be clear.
            if (fill_ok) filled[bus.wr_tag] <= 1'b1;
            if (bus.wr_en && filled[bus.wr_tag]) wr_err_q <= 1'b1;
            in_flight <= fetch;
            case ({alloc, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fifo_cnt <= 2'd0;
        else if (in_flight && !pop) fifo_cnt <= fifo_cnt + 2'd1;
        else if (!in_flight && pop) fifo_cnt <= fifo_cnt - 2'd1;
    end

    // Payload slots carry no reset; fifo_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        case ({in_flight, pop})
            2'b10: begin
                if (fifo_cnt == 2'd0) fifo_q0 <= ram_q;
                else                  fifo_q1 <= ram_q;
            end
            2'b01: fifo_q0 <= fifo_q1;
            2'b11: begin
                if (fifo_cnt == 2'd1) fifo_q0 <= ram_q;
                else begin
                    fifo_q0 <= fifo_q1;
                    fifo_q1 <= ram_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.alloc_gnt = alloc;
    assign bus.alloc_tag = tail;
    assign bus.rd_valid  = (fifo_cnt != 2'd0);
    assign bus.rd_data   = fifo_q0;
    assign bus.count     = cnt;
    assign bus.full      = full;
    assign bus.empty     = (cnt == '0);
    assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl at DEPTH=8, DATA_W=32: vector tables plus corner sequences.
module tb_rob_ctrl;
    localparam int DW = 32;
    localparam int DP = 8;

    typedef struct {
        logic        alloc_req;
        logic        wr_en;
        logic [2:0]  wr_tag;
        logic [31:0] wr_data;
        logic        rd_ready;
        logic        e_gnt;
        logic [2:0]  e_tag;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_count;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    rob_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    rob_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_tag    = '0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(logic ar, logic we, logic [2:0] wt, logic [31:0] wd, logic rr,
                                logic eg, logic [2:0] et, logic ev, logic [31:0] ed,
                                logic [3:0] ec, logic ef, logic ee);
        vec_t v;
        v.alloc_req = ar; v.wr_en = we; v.wr_tag = wt; v.wr_data = wd; v.rd_ready = rr;
        v.e_gnt = eg; v.e_tag = et; v.e_valid = ev; v.e_data = ed;
        v.e_count = ec; v.e_full = ef; v.e_empty = ee;
        return v;
    endfunction

    task automatic run_vecs(input int lo, input int hi, input string tname);
        for (int i = lo; i < hi; i++) begin
            bus.alloc_req = vq[i].alloc_req;
            bus.wr_en     = vq[i].wr_en;
            bus.wr_tag    = vq[i].wr_tag;
            bus.wr_data   = vq[i].wr_data;
            bus.rd_ready  = vq[i].rd_ready;
            #1;
            chk($sformatf("%s[%0d].gnt", tname, i - lo), 32'(bus.alloc_gnt), 32'(vq[i].e_gnt));
            if (vq[i].e_gnt)
                chk($sformatf("%s[%0d].tag", tname, i - lo), 32'(bus.alloc_tag), 32'(vq[i].e_tag));
            chk($sformatf("%s[%0d].valid", tname, i - lo), 32'(bus.rd_valid), 32'(vq[i].e_valid));
            if (vq[i].e_valid)
                chk($sformatf("%s[%0d].data", tname, i - lo), bus.rd_data, vq[i].e_data);
            chk($sformatf("%s[%0d].count", tname, i - lo), 32'(bus.count), 32'(vq[i].e_count));
            chk($sformatf("%s[%0d].full", tname, i - lo), 32'(bus.full), 32'(vq[i].e_full));
            chk($sformatf("%s[%0d].empty", tname, i - lo), 32'(bus.empty), 32'(vq[i].e_empty));
            tick();
        end
        idle();
    endtask

    initial begin
        int          na, nb, got_n;
        logic [31:0] got [3];
        logic [2:0]  tag;
        logic        seen;

        // Table A: fill to full, rejected 9th request, wrap of tail.
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1, 0, 0, 0, 1, 1, 3'(i), 0, 0, 4'(i), 0, i == 0));
        vq.push_back(mk(1, 0, 0, 0,     1, 0, 0, 0, 0,     8, 1, 0));
        vq.push_back(mk(0, 1, 0, 32'h70,1, 0, 0, 0, 0,     8, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,     1, 0, 0, 0, 0,     8, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,     1, 0, 0, 0, 0,     8, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,     1, 0, 0, 1, 32'h70,8, 1, 0));
        vq.push_back(mk(1, 0, 0, 0,     1, 1, 0, 0, 0,     7, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,     1, 0, 0, 0, 0,     8, 1, 0));
        na = vq.size();
        // Table B: reverse-order fills, in-order back-to-back drain.
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1, 0, 0, 0, 1, 1, 3'(i), 0, 0, 4'(i), 0, i == 0));
        vq.push_back(mk(0, 1, 3, 32'hD3, 1, 0, 0, 0, 0,      4, 0, 0));
        vq.push_back(mk(0, 1, 2, 32'hD2, 1, 0, 0, 0, 0,      4, 0, 0));
        vq.push_back(mk(0, 1, 1, 32'hD1, 1, 0, 0, 0, 0,      4, 0, 0));
        vq.push_back(mk(0, 1, 0, 32'hD0, 1, 0, 0, 0, 0,      4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 0,      4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 0,      4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 32'hD0, 4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 32'hD1, 3, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 32'hD2, 2, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 32'hD3, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0, 0,      0, 0, 1));
        nb = vq.size();

        // Reset state; alloc_gnt follows alloc_req even under reset.
        idle();
        bus.alloc_req = 1'b1;
        #3;
        chk("rst.gnt",    32'(bus.alloc_gnt), 1);
        chk("rst.valid",  32'(bus.rd_valid), 0);
        chk("rst.count",  32'(bus.count), 0);
        chk("rst.empty",  32'(bus.empty), 1);
        chk("rst.full",   32'(bus.full), 0);
        chk("rst.wr_err", 32'(bus.wr_err), 0);
        do_reset();

        run_vecs(0, na, "full");
        do_reset();
        run_vecs(na, nb, "order");
        do_reset();

        // Fill-to-valid latency and data hold under back-pressure.
        bus.alloc_req = 1'b1; tick(); tick(); bus.alloc_req = 1'b0;
        bus.rd_ready = 1'b1;
        bus.wr_en = 1'b1; bus.wr_tag = 3'd0; bus.wr_data = 32'h11;
        tick();
        bus.wr_en = 1'b0;
        chk("lat.t0.valid", 32'(bus.rd_valid), 0);
        tick();
        chk("lat.t1.valid", 32'(bus.rd_valid), 0);
        tick();
        chk("lat.t2.valid", 32'(bus.rd_valid), 1);
        chk("lat.t2.data",  bus.rd_data, 32'h11);
        bus.rd_ready = 1'b0;
        bus.wr_en = 1'b1; bus.wr_tag = 3'd1; bus.wr_data = 32'h22;
        tick();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold[%0d].valid", i), 32'(bus.rd_valid), 1);
            chk($sformatf("hold[%0d].data", i), bus.rd_data, 32'h11);
            tick();
        end
        bus.rd_ready = 1'b1;
        tick();
        chk("hold.next.data",  bus.rd_data, 32'h22);
        chk("hold.next.count", 32'(bus.count), 1);
        tick();
        chk("hold.drain.valid", 32'(bus.rd_valid), 0);
        chk("hold.drain.empty", 32'(bus.empty), 1);
        do_reset();

        // 20 single-entry rounds wrapping the tag space.
        bus.rd_ready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            bus.alloc_req = 1'b1;
            #1;
            chk($sformatf("wrap[%0d].tag", r), 32'(bus.alloc_tag), 32'(r % 8));
            tag = 3'(r % 8);
            tick();
            bus.alloc_req = 1'b0;
            bus.wr_en = 1'b1; bus.wr_tag = tag; bus.wr_data = 32'h100 + 32'(r);
            tick();
            bus.wr_en = 1'b0;
            seen = 1'b0;
            for (int w = 0; w < 10 && !seen; w++) begin
                if (bus.rd_valid) begin
                    seen = 1'b1;
                    chk($sformatf("wrap[%0d].data", r), bus.rd_data, 32'h100 + 32'(r));
                end
                tick();
            end
            if (!seen) chk($sformatf("wrap[%0d].timeout", r), 0, 1);
        end
        chk("wrap.count", 32'(bus.count), 0);
        chk("wrap.empty", 32'(bus.empty), 1);
        do_reset();

        // Double fill: sticky error, first data kept.
        bus.alloc_req = 1'b1; tick(); tick(); tick(); bus.alloc_req = 1'b0;
        bus.wr_en = 1'b1; bus.wr_tag = 3'd2; bus.wr_data = 32'hAA;
        tick();
        chk("dbl.first.wr_err", 32'(bus.wr_err), 0);
        bus.wr_data = 32'hBB;
        tick();
        chk("dbl.second.wr_err", 32'(bus.wr_err), 1);
        bus.wr_tag = 3'd0; bus.wr_data = 32'hA0; tick();
        bus.wr_tag = 3'd1; bus.wr_data = 32'hA1; tick();
        bus.wr_en = 1'b0;
        bus.rd_ready = 1'b1;
        got_n = 0;
        for (int w = 0; w < 20 && got_n < 3; w++) begin
            if (bus.rd_valid) begin
                got[got_n] = bus.rd_data;
                got_n++;
            end
            tick();
        end
        chk("dbl.pops", 32'(got_n), 3);
        if (got_n == 3) begin
            chk("dbl.pop0", got[0], 32'hA0);
            chk("dbl.pop1", got[1], 32'hA1);
            chk("dbl.pop2", got[2], 32'hAA);
        end
        chk("dbl.sticky", 32'(bus.wr_err), 1);
        do_reset();
        chk("dbl.rst.wr_err", 32'(bus.wr_err), 0);

        // Reset with outstanding entries and data waiting at the output.
        bus.alloc_req = 1'b1;
        repeat (5) tick();
        bus.alloc_req = 1'b0;
        bus.wr_en = 1'b1; bus.wr_tag = 3'd0; bus.wr_data = 32'h55;
        tick();
        bus.wr_en = 1'b0;
        tick(); tick();
        chk("mid.pre.valid", 32'(bus.rd_valid), 1);
        chk("mid.pre.count", 32'(bus.count), 5);
        rst = 1'b1;
        tick();
        chk("mid.valid", 32'(bus.rd_valid), 0);
        chk("mid.count", 32'(bus.count), 0);
        chk("mid.empty", 32'(bus.empty), 1);
        rst = 1'b0;
        bus.alloc_req = 1'b1;
        #1;
        chk("mid.gnt", 32'(bus.alloc_gnt), 1);
        chk("mid.tag", 32'(bus.alloc_tag), 0);
        tick();
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end
endmodule
